// File: rtl/stage_if_prefetch.sv
// Byte-serial instruction fetch stage with a DEPTH-entry prefetch queue toward stage_id.
// Optional macro STAGE_IF_BRANCH_HOLD_EN: stop fetching after a control-flow instruction until redirect.
module stage_if_prefetch #(
  parameter int                ADDR_W     = 32,
  parameter int                INST_BYTES = 4,
  parameter int                DEPTH      = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    redirect_i,
  input  logic [ADDR_W-1:0]       redirect_pc_i,
  input  logic [7:0]              mem_data_i,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic                    mem_we_o,
  output logic                    inst_valid_o,
  input  logic                    inst_ready_i,
  output logic [8*INST_BYTES-1:0] inst_o,
  output logic [ADDR_W-1:0]       pc_o,
  output logic                    branch_sign_o
);

  localparam int INST_W = 8 * INST_BYTES;
  localparam int CNT_W  = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(INST_BYTES - 1);
  localparam logic [6:0] BRANCH_OP = 7'h63;
  localparam logic [6:0] JAL_OP    = 7'h6F;
  localparam logic [6:0] JALR_OP   = 7'h67;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [INST_W-1:0] inst_buf_q, inst_buf_d;
  logic [INST_W-1:0] shifted;
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W:0]    occ_after;
  logic              enq, deq, slot_free, hold_req;

  function automatic logic is_ctrl(input logic [INST_W-1:0] inst);
    return (inst[6:0] == BRANCH_OP) || (inst[6:0] == JAL_OP) || (inst[6:0] == JALR_OP);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == DEPTH - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  // Newest byte enters the top lane; after INST_BYTES shifts byte 0 lands in bits [7:0].
  assign shifted   = (inst_buf_q >> 8) | (INST_W'(mem_data_i) << (INST_W - 8));

  assign deq       = inst_valid_o && inst_ready_i && !redirect_i;
  assign enq       = (state_q == DRAIN) && !redirect_i;
  assign occ_after = {1'b0, occ_q} + (OCC_W+1)'(enq) - (OCC_W+1)'(deq);
  assign slot_free = occ_after < (OCC_W+1)'(DEPTH);

`ifdef STAGE_IF_BRANCH_HOLD_EN
  assign hold_req = is_ctrl(shifted);
`else
  assign hold_req = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    inst_buf_d = inst_buf_q;
    if (redirect_i) begin
      state_d    = FETCH;
      byte_cnt_d = '0;
      fetch_pc_d = redirect_pc_i;
      mem_addr_d = redirect_pc_i;
    end else begin
      case (state_q)
        IDLE: begin
          if (slot_free) begin
            state_d    = FETCH;
            mem_addr_d = fetch_pc_q;
          end
        end
        FETCH: begin
          if (byte_cnt_q != '0) inst_buf_d = shifted;
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = DRAIN;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
            mem_addr_d = mem_addr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          byte_cnt_d = '0;
          fetch_pc_d = fetch_pc_q + ADDR_W'(INST_BYTES);
          if (hold_req) begin
            state_d = HOLD;
          end else if (slot_free) begin
            state_d    = FETCH;
            mem_addr_d = fetch_pc_q + ADDR_W'(INST_BYTES);
          end else begin
            state_d = IDLE;
          end
        end
        HOLD:    state_d = HOLD;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= '0;
      inst_buf_q <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      inst_buf_q <= inst_buf_d;
    end
  end

  // Redirect empties the queue and wins over any enqueue/dequeue in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (rdy) begin
      if (redirect_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        occ_q    <= '0;
      end else begin
        if (enq) begin
          inst_mem_q[wr_ptr_q] <= shifted;
          pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
          wr_ptr_q             <= ptr_inc(wr_ptr_q);
        end
        if (deq) rd_ptr_q <= ptr_inc(rd_ptr_q);
        occ_q <= OCC_W'(occ_after);
      end
    end
  end

  assign inst_valid_o  = (occ_q != '0);
  assign inst_o        = inst_mem_q[rd_ptr_q];
  assign pc_o          = pc_mem_q[rd_ptr_q];
  assign branch_sign_o = inst_valid_o && is_ctrl(inst_o);
  assign mem_addr_o    = mem_addr_q;
  assign mem_we_o      = 1'b0;

endmodule

// File: tb/tb_stage_if_prefetch.sv
// Scoreboard bench for stage_if_prefetch: a byte-memory model predicts the accepted {pc, inst} stream.
// Honours STAGE_IF_BRANCH_HOLD_EN when predicting the stream after control-flow instructions.
module tb_stage_if_prefetch;

  logic        clk = 1'b0;
  logic        rst, rdy, redirect_i, inst_ready_i;
  logic [31:0] redirect_pc_i;
  logic [7:0]  mem_data_i;
  logic [31:0] mem_addr_o, inst_o, pc_o;
  logic        mem_we_o, inst_valid_o, branch_sign_o;

  always #5 clk = ~clk;

  stage_if_prefetch dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .mem_data_i(mem_data_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .pc_o(pc_o), .branch_sign_o(branch_sign_o)
  );

  // Byte memory answering one cycle later; it shares the global enable with the fetch stage.
  logic [7:0] mem [1024];
  always @(posedge clk) if (rdy) mem_data_i <= mem[mem_addr_o[9:0]];

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        br;
  } exp_t;

  exp_t expQ[$];
  int   hsCycles[$];
  exp_t monE;
  int   testsRun = 0;
  int   testsFailed = 0;
  int   n;
  logic found;
  logic [7:0] b;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] refInst(input logic [31:0] pc);
    logic [31:0] r;
    logic [31:0] a;
    for (int k = 0; k < 4; k++) begin
      a = pc + 32'(k);
      r[8*k +: 8] = mem[a[9:0]];
    end
    return r;
  endfunction

  function automatic logic refIsCtrl(input logic [31:0] inst);
    return (inst[6:0] == 7'h63) || (inst[6:0] == 7'h6F) || (inst[6:0] == 7'h67);
  endfunction

  // Straight-line program order from a start address is what stage_id must see.
  task automatic pushSequence(input logic [31:0] startPc);
    exp_t e;
    expQ.delete();
    for (int k = 0; k < 80; k++) begin
      e.pc   = startPc + 32'(4 * k);
      e.inst = refInst(e.pc);
      e.br   = refIsCtrl(e.inst);
      expQ.push_back(e);
`ifdef STAGE_IF_BRANCH_HOLD_EN
      if (e.br) break;
`endif
    end
  endtask

  task automatic applyStimulus(input logic rstV, input logic rdyV, input logic redirV,
                               input logic [31:0] pcV, input logic readyV);
    @(posedge clk);
    #1;
    rst           = rstV;
    rdy           = redirV ? 1'b1 : rdyV;
    redirect_i    = redirV;
    redirect_pc_i = pcV;
    inst_ready_i  = readyV;
    if (rstV) pushSequence(32'h0);
    else if (redirV) pushSequence(pcV);
  endtask

  // Monitor: every accepted head entry is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst === 1'b0 && rdy && !redirect_i) begin
      if (inst_valid_o && inst_ready_i) begin
        hsCycles.push_back(cycleCnt);
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL sb_unexpected: got pc %0h, expected no instruction", pc_o);
        end else begin
          monE = expQ.pop_front();
          checkOutput("sb_pc", 64'(pc_o), 64'(monE.pc));
          checkOutput("sb_inst", 64'(inst_o), 64'(monE.inst));
          checkOutput("sb_branch", 64'(branch_sign_o), 64'(monE.br));
        end
      end else if (!inst_valid_o) begin
        checkOutput("empty_branch", 64'(branch_sign_o), 64'd0);
      end
    end
  end

  function automatic logic [31:0] randPc();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'hFFFF_FFFE;
    if (sel == 1) return $urandom & 32'h0000_03FF;
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  initial begin
    rst = 1'b1; rdy = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; inst_ready_i = 1'b0;
    for (int w = 0; w < 256; w++) begin
      b = 8'($urandom);
      if (w >= 64 && $urandom_range(0, 9) < 3) begin
        case ($urandom_range(0, 2))
          0:       b[6:0] = 7'h63;
          1:       b[6:0] = 7'h6F;
          default: b[6:0] = 7'h67;
        endcase
      end else if (refIsCtrl({24'h0, b})) begin
        b[6:0] = 7'h13;
      end
      mem[4*w]     = b;
      mem[4*w + 1] = 8'($urandom);
      mem[4*w + 2] = 8'($urandom);
      mem[4*w + 3] = 8'($urandom);
    end
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;

    // Reset values, then the 6-cycle first-instruction latency with stage_id stalled.
    repeat (3) applyStimulus(1, 1, 0, 0, 0);
    checkOutput("rst_valid", 64'(inst_valid_o), 64'd0);
    checkOutput("rst_inst", 64'(inst_o), 64'd0);
    checkOutput("rst_pc", 64'(pc_o), 64'd0);
    checkOutput("rst_addr", 64'(mem_addr_o), 64'd0);
    checkOutput("rst_we", 64'(mem_we_o), 64'd0);
    checkOutput("rst_branch", 64'(branch_sign_o), 64'd0);
    applyStimulus(0, 1, 0, 0, 0);
    found = 1'b0; n = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      if (inst_valid_o) begin found = 1'b1; n = i; end
    end
    checkOutput("reset_latency", 64'(n), 64'd6);
    checkOutput("first_inst", 64'(inst_o), 64'h0010_0513);
    checkOutput("first_pc", 64'(pc_o), 64'd0);

    // Queue fills to DEPTH and the memory address stops at the last byte of pc 4.
    repeat (25) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("full_addr", 64'(mem_addr_o), 64'd7);
    checkOutput("full_valid", 64'(inst_valid_o), 64'd1);
    checkOutput("full_head_pc", 64'(pc_o), 64'd0);

    // One dequeue resumes fetch at pc 8; redirect lands on its third byte.
    applyStimulus(0, 1, 0, 0, 1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      if (mem_addr_o == 32'd10) found = 1'b1;
    end
    checkOutput("resume_to_addr10", 64'(found), 64'd1);
    applyStimulus(0, 1, 1, 32'h100, 0);
    found = 1'b0; n = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      if (i == 1) begin
        checkOutput("redir_flush_valid", 64'(inst_valid_o), 64'd0);
        checkOutput("redir_addr", 64'(mem_addr_o), 64'h100);
      end
      if (inst_valid_o) begin found = 1'b1; n = i; end
    end
    checkOutput("redir_latency", 64'(n), 64'd6);
    checkOutput("redir_pc", 64'(pc_o), 64'h100);

    // Continuous acceptance of straight-line code: one instruction every 5 cycles.
    applyStimulus(1, 1, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 1);
    hsCycles.delete();
    for (int i = 0; i < 100 && hsCycles.size() < 5; i++) applyStimulus(0, 1, 0, 0, 1);
    checkOutput("throughput_count", 64'(hsCycles.size() >= 5), 64'd1);
    if (hsCycles.size() >= 5)
      for (int i = 1; i < 5; i++)
        checkOutput("throughput_gap", 64'(hsCycles[i] - hsCycles[i-1]), 64'd5);

    // Three-cycle rdy pause in the middle of the fetch at 0x40.
    applyStimulus(0, 1, 1, 32'h40, 1);
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("pause_addr_a", 64'(mem_addr_o), 64'h41);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("pause_addr_b", 64'(mem_addr_o), 64'h41);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("pause_addr_c", 64'(mem_addr_o), 64'h41);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("pause_addr_d", 64'(mem_addr_o), 64'h41);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("pause_addr_e", 64'(mem_addr_o), 64'h42);
    repeat (20) applyStimulus(0, 1, 0, 0, 1);

    // Random traffic: stalls, rdy gaps, redirects (incl. address wrap) and a reset+redirect collision.
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000)
        applyStimulus(1, 1, 1, 32'h200, 1);
      else if ($urandom_range(0, 99) < 3)
        applyStimulus(0, 1, 1, randPc(), $urandom_range(0, 3) != 0);
      else
        applyStimulus(0, $urandom_range(0, 9) != 0, 0, 0, $urandom_range(0, 9) < 7);
    end
    repeat (40) applyStimulus(0, 1, 0, 0, 1);
    checkOutput("end_we", 64'(mem_we_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
